// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared integer register-file constants and an address helper for
//           the pipelined core.
// Contents: XLEN, NREGS, REG_AW, REG_ZERO; reg_legal() tells whether an
//           address names a real, writable register.
// Revision: 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned REG_AW   = $clog2(NREGS);
  localparam int unsigned REG_ZERO = 0;

  // True for an address inside the file that is not the hardwired-zero register.
  function automatic logic reg_legal(input int unsigned addr,
                                     input int unsigned nregs,
                                     input logic        zero_reg);
    return (addr < nregs) && !(zero_reg && (addr == REG_ZERO));
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : regfile_scoreboard
// Purpose : Per-register busy bits for hazard detection. A register becomes
//           busy when its producer is issued and is cleared at writeback.
// Ports   : clk, rst_n (async, active low)
//           wr_en/wr_addr     writeback clears busy
//           rsv_en/rsv_addr   reservation request, rsv_ok accepts it (comb.)
//           flush             clears every busy bit
//           busy              busy vector, busy_cnt = popcount(busy)
// Revision: 1.0  initial release
// ============================================================================
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             flush,
  output logic             rsv_ok,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    busy_cnt
);

  logic rsv_legal;
  logic wr_legal;
  logic wr_hits_rsv;
  logic rsv_free;
  logic set_busy;
  logic cnt_inc;
  logic cnt_dec;

  always_comb begin
    rsv_legal   = reg_legal(32'(rsv_addr), NREGS, ZERO_REG != 0);
    wr_legal    = reg_legal(32'(wr_addr), NREGS, ZERO_REG != 0);
    wr_hits_rsv = wr_en && (wr_addr == rsv_addr);
    rsv_free    = rsv_legal ? !busy[rsv_addr] : 1'b1;
    // A busy destination is accepted only when its producer retires this cycle.
    rsv_ok      = rsv_en && !flush && (rsv_free || wr_hits_rsv);
    set_busy    = rsv_ok && rsv_legal;
    // Clear-then-set on the same register nets to zero in the counter:
    // cnt_dec counts the retiring producer, cnt_inc counts the new one.
    cnt_dec     = wr_en && wr_legal && busy[wr_addr];
    cnt_inc     = set_busy && (rsv_free || wr_hits_rsv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_en && wr_legal) busy[wr_addr] <= 1'b0;
      // Later assignment wins: the newly issued producer owns the register.
      if (set_busy) busy[rsv_addr] <= 1'b1;
      busy_cnt <= busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module  : regfile_sb
// Purpose : Integer register file with NRD combinational read ports, one
//           writeback port, optional hardwired x0, write->read bypass and a
//           busy scoreboard for RAW/WAW stalls.
// Ports   : clk, rst_n (async, active low)
//           rd_addr/rd_data/rd_busy   packed per-port read interface
//           wr_en/wr_addr/wr_data     writeback port
//           rsv_en/rsv_addr/rsv_ok    destination reservation at issue
//           flush                     clear all busy bits
//           busy_cnt                  number of busy registers
// Revision: 1.0  initial release
// ============================================================================
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_legal;

  assign wr_legal = reg_legal(32'(wr_addr), NREGS, ZERO_REG != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_en && wr_legal) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .rsv_ok   (rsv_ok),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            legal;
    logic            hit;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr[i*AW +: AW];

    always_comb begin
      legal = reg_legal(32'(addr), NREGS, ZERO_REG != 0);
      // rst_n gates the bypass so the ports read zero while reset is held.
      hit   = (BYPASS != 0) && rst_n && wr_en && (wr_addr == addr) && legal;
      data  = '0;
      bsy   = 1'b0;
      if (hit) begin
        data = wr_data;
      end else if (legal) begin
        data = regs[addr];
        bsy  = busy[addr];
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_sb
// Purpose : Directed self-checking bench for regfile_sb. Expected values are
//           queued as each step is driven and popped when the output is read.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_sb;

  localparam int AW   = 5;
  localparam int XLEN = 32;
  localparam int NRD  = 2;

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ok;
  logic                flush;
  logic [AW:0]         busy_cnt;

  int total = 0;
  int bad   = 0;
  logic [63:0] expq[$];

  regfile_sb #(
    .XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [63:0] v);
    expq.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $error("FAIL %s: nothing queued, observed=%0h", tag, obs);
      return;
    end
    exp = expq.pop_front();
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;

    // 1: reset state, bypass suppressed while reset is held
    rd_addr = {5'd5, 5'd5};
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
    #1;
    push(0); check("rst_rd0", 64'(rd_data[31:0]));
    push(0); check("rst_rd1", 64'(rd_data[63:32]));
    push(0); check("rst_busy", 64'(rd_busy));
    push(0); check("rst_cnt", 64'(busy_cnt));
    @(negedge clk);
    wr_en = 1'b0; rst_n = 1'b1;
    #1;
    push(0); check("post_rst_rd0", 64'(rd_data[31:0]));

    // 2: same-cycle bypass, then registered value
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'd24; rd_addr[4:0] = 5'd1;
    #1;
    push(24); check("bypass_rd0", 64'(rd_data[31:0]));
    tick(); wr_en = 1'b0; #1;
    push(24); check("stored_rd0", 64'(rd_data[31:0]));

    // 3: x0 hardwired zero
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; rd_addr[4:0] = 5'd0;
    #1;
    push(0); check("x0_bypass", 64'(rd_data[31:0]));
    tick(); wr_en = 1'b0; #1;
    push(0); check("x0_read", 64'(rd_data[31:0]));
    rsv_en = 1'b1; rsv_addr = 5'd0; #1;
    push(1); check("x0_rsv_ok", 64'(rsv_ok));
    tick(); rsv_en = 1'b0; #1;
    push(0); check("x0_cnt", 64'(busy_cnt));
    push(0); check("x0_busy", 64'(rd_busy[0]));

    // 4: reservation, WAW refusal, same-cycle clear+reserve, clear
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd3; rd_addr[9:5] = 5'd3; #1;
    push(1); check("rsv3_ok", 64'(rsv_ok));
    tick(); #1;
    push(1); check("rsv3_cnt", 64'(busy_cnt));
    push(1); check("rsv3_busy", 64'(rd_busy[1]));
    push(0); check("rsv3_waw", 64'(rsv_ok));
    tick(); #1;
    push(1); check("rsv3_waw_cnt", 64'(busy_cnt));
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd77; #1;
    push(1); check("rsv3_wr_ok", 64'(rsv_ok));
    push(0); check("rsv3_wr_bypbusy", 64'(rd_busy[1]));
    push(77); check("rsv3_wr_bypdata", 64'(rd_data[63:32]));
    tick(); rsv_en = 1'b0; wr_en = 1'b0; #1;
    push(1); check("rsv3_wr_cnt", 64'(busy_cnt));
    push(1); check("rsv3_wr_busy", 64'(rd_busy[1]));
    push(77); check("rsv3_wr_data", 64'(rd_data[63:32]));
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd78;
    tick(); wr_en = 1'b0; #1;
    push(0); check("clr3_cnt", 64'(busy_cnt));
    push(0); check("clr3_busy", 64'(rd_busy[1]));

    // 5: three reservations, then flush with a reservation and a write
    rsv_en = 1'b1;
    rsv_addr = 5'd4; tick();
    rsv_addr = 5'd5; tick();
    rsv_addr = 5'd6; tick(); #1;
    push(3); check("rsv456_cnt", 64'(busy_cnt));
    flush = 1'b1; rsv_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; #1;
    push(0); check("flush_rsv_ok", 64'(rsv_ok));
    tick(); flush = 1'b0; rsv_en = 1'b0; wr_en = 1'b0;
    rd_addr = {5'd4, 5'd9}; #1;
    push(0); check("flush_cnt", 64'(busy_cnt));
    push(0); check("flush_busy4", 64'(rd_busy[1]));
    push(32'h55); check("flush_wr9", 64'(rd_data[31:0]));

    // Reserve one register while a different busy one retires: net zero
    rsv_en = 1'b1; rsv_addr = 5'd10; tick(); #1;
    push(1); check("rsv10_cnt", 64'(busy_cnt));
    rsv_addr = 5'd11; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd1;
    tick(); rsv_en = 1'b0; wr_en = 1'b0; #1;
    push(1); check("swap_cnt", 64'(busy_cnt));

    // 6: asynchronous reset discards in-flight reservations
    rsv_en = 1'b1; rsv_addr = 5'd8; rd_addr = {5'd1, 5'd8};
    tick(); rsv_en = 1'b0; #1;
    push(2); check("rsv8_cnt", 64'(busy_cnt));
    push(1); check("rsv8_busy", 64'(rd_busy[0]));
    rst_n = 1'b0; #1;
    push(0); check("arst_busy", 64'(rd_busy[0]));
    push(0); check("arst_cnt", 64'(busy_cnt));
    @(negedge clk);
    rst_n = 1'b1; #1;
    push(0); check("arst_rd_x1", 64'(rd_data[63:32]));
    push(0); check("arst_rd_x8", 64'(rd_data[31:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
